// File: rtl/aluctr_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
package aluctr_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [OPC_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_SLL  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_SRL  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_SRA  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_NOR  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'b1101;
  localparam logic [OPC_W-1:0] OP_SLTU = 4'b1111;

  // Low two func bits of an md op select the kind directly.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_kind_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_e;

endpackage

// File: rtl/aluctr_md_if.sv
// Execute-stage control bus between the pipeline and the ALU control block.
interface aluctr_md_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
);
  logic [1:0]       alu_ctl;
  logic [5:0]       func;
  logic             valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [OP_W-1:0]  alu_op;
  logic             sel_hi;
  logic             sel_lo;
  logic             illegal;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_ctl, func, valid, src_a, src_b,
    input  alu_op, sel_hi, sel_lo, illegal, stall, busy, hi, lo
  );

  modport slave (
    input  alu_ctl, func, valid, src_a, src_b,
    output alu_op, sel_hi, sel_lo, illegal, stall, busy, hi, lo
  );
endinterface

// File: rtl/aluctr_md_muldiv_seq.sv
// Iterative radix-2 multiply/divide on sign magnitudes, writing HI/LO in the FIX state.
module muldiv_seq
  import aluctr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_kind_e         kind,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             idle,
  output logic             fix,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_next;
  logic [WIDTH:0]   div_part;
  logic             div_ge;
  logic [ACC_W-1:0] div_next;
  logic [ACC_W-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // acc holds {upper, lower} for mult and {remainder, dividend/quotient} for div.
  always_comb begin
    is_signed = (kind == MD_MULT) || (kind == MD_DIV);
    a_neg     = is_signed & src_a[WIDTH-1];
    b_neg     = is_signed & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;

    mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = ACC_W'({mul_sum, acc[WIDTH-1:0]} >> 1);

    div_part  = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_part >= {1'b0, opnd};
    div_next  = div_ge ? {WIDTH'(div_part - {1'b0, opnd}), acc[WIDTH-2:0], 1'b1}
                       : {acc[ACC_W-2:0], 1'b0};

    prod      = neg_q ? -acc : acc;
    quo       = acc[WIDTH-1:0];
    rem       = acc[ACC_W-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= (kind == MD_DIV) || (kind == MD_DIVU);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (src_b == '0);
            cnt    <= '0;
            if ((kind == MD_DIV) || (kind == MD_DIVU)) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div) begin
            lo <= b_zero ? '1 : (neg_q ? -quo : quo);
            hi <= neg_r ? -rem : rem;
          end else begin
            hi <= prod[ACC_W-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idle = (state == S_IDLE);
  assign fix  = (state == S_FIX);

endmodule

// File: rtl/aluctr_md.sv
// ALU control decoder with stall generation around the mul/div sequencer.
module aluctr_md
  import aluctr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  aluctr_md_if.slave  bus
);
  logic [OPC_W-1:0] op_code;
  logic             hi_sel;
  logic             lo_sel;
  logic             bad_func;
  logic             md_op;
  logic             seq_idle;
  logic             seq_fix;

  // Decode depends only on alu_ctl/func so the ALU sees it in the same cycle.
  always_comb begin
    op_code  = OP_ADD;
    hi_sel   = 1'b0;
    lo_sel   = 1'b0;
    bad_func = 1'b0;
    md_op    = 1'b0;
    unique case (bus.alu_ctl)
      ALUOP_BEQ: op_code = OP_SUB;
      ALUOP_RTYPE: begin
        unique case (bus.func)
          F_ADD, F_ADDU: op_code = OP_ADD;
          F_SUB, F_SUBU: op_code = OP_SUB;
          F_AND:         op_code = OP_AND;
          F_OR:          op_code = OP_OR;
          F_XOR:         op_code = OP_XOR;
          F_NOR:         op_code = OP_NOR;
          F_SLT:         op_code = OP_SLT;
          F_SLTU:        op_code = OP_SLTU;
          F_SLL:         op_code = OP_SLL;
          F_SRL:         op_code = OP_SRL;
          F_SRA:         op_code = OP_SRA;
          F_MFHI:        hi_sel  = 1'b1;
          F_MFLO:        lo_sel  = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: md_op = 1'b1;
          default:       bad_func = 1'b1;
        endcase
      end
      default: op_code = OP_ADD;
    endcase
  end

  assign bus.alu_op  = OP_W'(op_code);
  assign bus.sel_hi  = hi_sel;
  assign bus.sel_lo  = lo_sel;
  assign bus.illegal = bad_func;
  assign bus.stall   = bus.valid & md_op & ~seq_fix;
  assign bus.busy    = ~seq_idle;

  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (bus.valid & md_op & seq_idle),
    .kind  (md_kind_e'(bus.func[1:0])),
    .src_a (bus.src_a),
    .src_b (bus.src_b),
    .idle  (seq_idle),
    .fix   (seq_fix),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

endmodule

// File: tb/tb_aluctr_md.sv
// Randomised bench for aluctr_md at WIDTH=8 against an arithmetic reference model.
module tb_aluctr_md;
  localparam int unsigned W  = 8;
  localparam int unsigned W2 = 2 * W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  logic [W-1:0] model_hi, model_lo;

  always #5 clk = ~clk;

  aluctr_md_if #(.WIDTH(W), .OP_W(4)) bus ();

  aluctr_md #(.WIDTH(W), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected HI/LO from plain integer arithmetic plus the two stated special cases.
  function automatic void ref_md(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
    int sa, sb;
    longint ua, ub;
    logic [W2-1:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    h  = '0;
    l  = '0;
    case (k)
      2'd0: begin p = W2'(sa * sb); h = p[W2-1:W]; l = p[W-1:0]; end
      2'd1: begin p = W2'(ua * ub); h = p[W2-1:W]; l = p[W-1:0]; end
      2'd2: begin
        if (b == '0) begin h = a; l = '1; end
        else begin l = W'(sa / sb); h = W'(sa % sb); end
      end
      default: begin
        if (b == '0) begin h = a; l = '1; end
        else begin l = W'(ua / ub); h = W'(ua % ub); end
      end
    endcase
  endfunction

  task automatic test_reset();
    bus.valid = 1'b0; bus.alu_ctl = 2'b00; bus.func = 6'd0; bus.src_a = '0; bus.src_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    model_hi = '0; model_lo = '0;
    checks++; if (bus.hi !== 8'h00) $display("FAIL reset_hi got=%h want=00", bus.hi); else passes++;
    checks++; if (bus.lo !== 8'h00) $display("FAIL reset_lo got=%h want=00", bus.lo); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else passes++;
    checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", bus.stall); else passes++;
  endtask

  task automatic test_decoder();
    logic [3:0] tab [int];
    logic [3:0] e_op;
    logic e_hi, e_lo, e_ill;
    tab[32] = 4'b0010; tab[33] = 4'b0010; tab[34] = 4'b0110; tab[35] = 4'b0110;
    tab[36] = 4'b0000; tab[37] = 4'b0001; tab[38] = 4'b1101; tab[39] = 4'b1100;
    tab[42] = 4'b0111; tab[43] = 4'b1111;
    tab[0]  = 4'b1000; tab[2]  = 4'b1001; tab[3]  = 4'b1010;
    tab[16] = 4'b0010; tab[18] = 4'b0010;
    tab[24] = 4'b0010; tab[25] = 4'b0010; tab[26] = 4'b0010; tab[27] = 4'b0010;
    bus.valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int f = 0; f < 64; f++) begin
        @(negedge clk);
        bus.alu_ctl = 2'(c); bus.func = 6'(f);
        bus.src_a = 8'($urandom); bus.src_b = 8'($urandom);
        #1;
        e_hi = 1'b0; e_lo = 1'b0; e_ill = 1'b0;
        if (c == 2) begin
          if (tab.exists(f)) e_op = tab[f]; else begin e_op = 4'b0010; e_ill = 1'b1; end
          e_hi = (f == 16);
          e_lo = (f == 18);
        end else begin
          e_op = (c == 1) ? 4'b0110 : 4'b0010;
        end
        checks++;
        if (bus.alu_op !== e_op || bus.sel_hi !== e_hi || bus.sel_lo !== e_lo || bus.illegal !== e_ill)
          $display("FAIL decode ctl=%0d func=%0d got op=%b hi=%b lo=%b ill=%b want op=%b hi=%b lo=%b ill=%b",
                   c, f, bus.alu_op, bus.sel_hi, bus.sel_lo, bus.illegal, e_op, e_hi, e_lo, e_ill);
        else passes++;
      end
    end
  endtask

  // Issue one md op, count stall cycles, then optionally follow with mflo.
  task automatic do_md(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit chain_mflo, input string tag);
    logic [W-1:0] eh, el;
    int n;
    ref_md(k, a, b, eh, el);
    @(negedge clk);
    bus.alu_ctl = 2'b10; bus.func = {4'b0110, k}; bus.valid = 1'b1; bus.src_a = a; bus.src_b = b;
    n = 0;
    #1;
    while (bus.stall === 1'b1 && n < 50) begin
      checks++;
      if (bus.hi !== model_hi || bus.lo !== model_lo)
        $display("FAIL %s hold got hi=%h lo=%h want hi=%h lo=%h", tag, bus.hi, bus.lo, model_hi, model_lo);
      else passes++;
      n++;
      @(negedge clk); #1;
    end
    checks++; if (n !== W + 1) $display("FAIL %s stall_len got=%0d want=%0d", tag, n, W + 1); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL %s fix_busy got=%b want=1", tag, bus.busy); else passes++;
    if (chain_mflo) bus.func = 6'b010010;
    else begin bus.valid = 1'b0; bus.func = 6'b100000; end
    @(negedge clk); #1;
    model_hi = eh; model_lo = el;
    checks++;
    if (bus.hi !== eh || bus.lo !== el)
      $display("FAIL %s result a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", tag, a, b, bus.hi, bus.lo, eh, el);
    else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL %s done_busy got=%b want=0", tag, bus.busy); else passes++;
    if (chain_mflo) begin
      checks++;
      if (bus.sel_lo !== 1'b1 || bus.stall !== 1'b0)
        $display("FAIL %s mflo got sel_lo=%b stall=%b want sel_lo=1 stall=0", tag, bus.sel_lo, bus.stall);
      else passes++;
    end
    bus.valid = 1'b0;
  endtask

  task automatic test_directed();
    do_md(2'd0, 8'hFD, 8'h05, 1'b0, "mult_m3x5");
    do_md(2'd3, 8'd200, 8'd7, 1'b0, "divu_200_7");
    do_md(2'd2, 8'hF9, 8'h02, 1'b0, "div_m7_2");
    do_md(2'd2, 8'h5A, 8'h00, 1'b0, "div_by_zero");
    do_md(2'd3, 8'h5A, 8'h00, 1'b0, "divu_by_zero");
    do_md(2'd2, 8'h80, 8'hFF, 1'b0, "div_min_m1");
    do_md(2'd1, 8'hFF, 8'hFF, 1'b0, "multu_max");
    do_md(2'd0, 8'h80, 8'h80, 1'b0, "mult_min_min");
  endtask

  task automatic test_back_to_back();
    do_md(2'd0, 8'h13, 8'hF1, 1'b1, "mult_then_mflo");
    do_md(2'd3, 8'hE5, 8'h0B, 1'b1, "divu_then_mflo");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      do_md(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] eh, el;
    int n;
    ref_md(2'd2, 8'h9C, 8'h0D, eh, el);
    @(negedge clk);
    bus.alu_ctl = 2'b10; bus.func = 6'b011010; bus.valid = 1'b1; bus.src_a = 8'h9C; bus.src_b = 8'h0D;
    repeat (3) @(negedge clk);
    bus.valid = 1'b0;
    n = 0;
    #1;
    while (bus.busy === 1'b1 && n < 30) begin n++; @(negedge clk); #1; end
    checks++; if (n >= 30) $display("FAIL flush_timeout busy=%b want=0", bus.busy); else passes++;
    model_hi = eh; model_lo = el;
    checks++;
    if (bus.hi !== eh || bus.lo !== el)
      $display("FAIL flush_result got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, eh, el);
    else passes++;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    bus.alu_ctl = 2'b10; bus.func = 6'b011000; bus.valid = 1'b1; bus.src_a = 8'h07; bus.src_b = 8'h09;
    repeat (3) @(negedge clk);
    rst = 1'b1; bus.valid = 1'b0;
    @(negedge clk); #1;
    model_hi = '0; model_lo = '0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", bus.busy); else passes++;
    checks++; if (bus.stall !== 1'b0) $display("FAIL midrst_stall got=%b want=0", bus.stall); else passes++;
    checks++;
    if (bus.hi !== 8'h00 || bus.lo !== 8'h00)
      $display("FAIL midrst_hilo got hi=%h lo=%h want hi=00 lo=00", bus.hi, bus.lo);
    else passes++;
    rst = 1'b0;
    do_md(2'd1, 8'h0C, 8'h0B, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_decoder();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
